// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fwd_pkg
//  Description : Shared types and constants for the fwd_sel_pipe operand
//                select stage (state encoding, default width, counter width).
//  Revision    : 1.0  initial release
// ============================================================================
package fwd_pkg;

    // Default data width of one forwarding source / operand channel
    localparam int XLEN_DEF = 32;

    // Width of the optional statistics counters
    localparam int CNT_W = 16;

    // Occupancy of the two-entry (main + skid) output buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fwd_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_mux
//  Description : Combinational NSRC:1 select for one operand channel. A
//                select value at or beyond NSRC yields zero data and flags
//                an error instead of picking an undefined source.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_sel_mux #(
    parameter int XLEN = 32,
    parameter int NSRC = 3,
    parameter int SELW = 2
) (
    input  logic [NSRC*XLEN-1:0] src_data_i,
    input  logic [SELW-1:0]      sel_i,
    output logic [XLEN-1:0]      data_o,
    output logic                 err_o
);

    // Default to "no match"; a matching in-range select overrides both outputs
    always_comb begin
        data_o = '0;
        err_o  = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (sel_i == SELW'(k)) begin
                data_o = src_data_i[k*XLEN +: XLEN];
                err_o  = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_sel_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_pipe
//  Description : Per-channel forwarding-source select followed by a two-entry
//                valid/ready skid buffer with synchronous flush. in_ready is
//                registered, so out_ready never reaches in_ready
//                combinationally.
//                Optional build macro FWD_SEL_STATS_EN enables the saturating
//                stall and select-error counters; otherwise they read zero.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_sel_pipe
    import fwd_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NSRC = 3,
    parameter  int NCH  = 2,
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [NCH*SELW-1:0]  sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*XLEN-1:0]  out_data,
    output logic [NCH-1:0]       sel_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     selerr_cnt
);

    logic [NCH*XLEN-1:0] w_data;
    logic [NCH-1:0]      w_err;

    fwd_state_e          state_q, state_d;
    logic                in_ready_q;
    logic [NCH*XLEN-1:0] main_data_q, skid_data_q;
    logic [NCH-1:0]      main_err_q,  skid_err_q;

    logic                w_accept, w_fire;
    logic                w_load_main, w_load_skid, w_skid_to_main;

    // One select/range-check slice per operand channel
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            fwd_sel_mux #(
                .XLEN (XLEN),
                .NSRC (NSRC),
                .SELW (SELW)
            ) u_mux (
                .src_data_i (src_data),
                .sel_i      (sel[c*SELW +: SELW]),
                .data_o     (w_data[c*XLEN +: XLEN]),
                .err_o      (w_err[c])
            );
        end
    endgenerate

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign sel_err   = main_err_q;

    assign w_accept  = in_valid & in_ready_q;
    assign w_fire    = out_valid & out_ready;

    // Next-state and entry-load decode; flush overrides everything and drops
    // any bundle accepted in the same cycle
    always_comb begin
        state_d        = state_q;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d     = ST_ONE;
                        w_load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_fire) begin
                        state_d     = ST_ONE;
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        state_d     = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_fire) begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_fire) begin
                        state_d        = ST_ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, registered ready and the two data entries (held unless loaded)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_err_q  <= '0;
            skid_data_q <= '0;
            skid_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (w_load_main) begin
                main_data_q <= w_data;
                main_err_q  <= w_err;
            end else if (w_skid_to_main) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (w_load_skid) begin
                skid_data_q <= w_data;
                skid_err_q  <= w_err;
            end
        end
    end

`ifdef FWD_SEL_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, selerr_cnt_q;
    logic             w_stall_inc, w_selerr_inc;

    // A bundle discarded by flush was never really accepted, so it is not counted
    assign w_stall_inc  = out_valid & ~out_ready;
    assign w_selerr_inc = w_accept & ~flush & (|w_err);

    // Saturating statistics counters; only reset clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            selerr_cnt_q <= '0;
        end else begin
            if (w_stall_inc) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (w_selerr_inc) begin
                selerr_cnt_q <= sat_inc(selerr_cnt_q);
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign selerr_cnt = selerr_cnt_q;
`else
    assign stall_cnt  = '0;
    assign selerr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_sel_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_sel_pipe
//  Description : Self-checking bench for fwd_sel_pipe (XLEN=32, NSRC=3,
//                NCH=2). Stimulus table plus directed multi-cycle sequences;
//                a queue scoreboard checks every output transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fwd_sel_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [95:0]  src_data;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [1:0]   sel_err;
    logic [15:0]  stall_cnt;
    logic [15:0]  selerr_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        logic [95:0] src;
        logic [3:0]  sel;
        logic [63:0] ed;
        logic [1:0]  ee;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[7];
    int   nvec  = 0;
    int   nmis  = 0;
    int   nfire = 0;

    fwd_sel_pipe #(
        .XLEN (32),
        .NSRC (3),
        .NCH  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .src_data   (src_data),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sel_err    (sel_err),
        .stall_cnt  (stall_cnt),
        .selerr_cnt (selerr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference select: in-range select picks the source, otherwise zero + error
    function automatic exp_t ref_sel(input logic [95:0] s_src, input logic [3:0] s_sel);
        exp_t r;
        logic [1:0] sc;
        r.data = '0;
        r.err  = '0;
        for (int c = 0; c < 2; c++) begin
            sc = s_sel[c*2 +: 2];
            if (sc < 2'd3) r.data[c*32 +: 32] = s_src[int'(sc)*32 +: 32];
            else           r.err[c] = 1'b1;
        end
        return r;
    endfunction

    // Present one bundle until accepted; leaves in_valid high on return
    task automatic send(input logic [95:0] s_src, input logic [3:0] s_sel,
                        input exp_t e, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        src_data = s_src;
        sel      = s_sel;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                sbq.push_back(e);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            nvec++;
            nmis++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance within 100 cycles");
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sbq.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    // Scoreboard: every transfer downstream must match the oldest accepted bundle
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            nfire++;
            if (sbq.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL sb_unexpected: got %h expected no output", out_data);
            end else begin
                e = sbq.pop_front();
                check("sb_data", out_data, e.data);
                check("sb_err", {62'd0, sel_err}, {62'd0, e.err});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   waits_total;
        int   f0;
        exp_t e;
        logic [95:0] r_src;
        logic [3:0]  r_sel;

        vecs[0] = '{96'h00000033_00000022_00000011, 4'b01_00, 64'h00000022_00000011, 2'b00};
        vecs[1] = '{96'h00000033_00000022_00000011, 4'b00_11, 64'h00000011_00000000, 2'b01};
        vecs[2] = '{96'h00000033_00000022_00000011, 4'b10_10, 64'h00000033_00000033, 2'b00};
        vecs[3] = '{96'h00000033_00000022_00000011, 4'b11_11, 64'h00000000_00000000, 2'b11};
        vecs[4] = '{96'hAAAA5555_DEADBEEF_12345678, 4'b00_10, 64'h12345678_AAAA5555, 2'b00};
        vecs[5] = '{96'hAAAA5555_DEADBEEF_12345678, 4'b01_01, 64'hDEADBEEF_DEADBEEF, 2'b00};
        vecs[6] = '{96'hAAAA5555_DEADBEEF_12345678, 4'b11_01, 64'h00000000_DEADBEEF, 2'b10};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        src_data  = '0;
        sel       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_data",   out_data,        64'd0);
        check("rst_sel_err",    64'(sel_err),    64'd0);
        check("rst_stall_cnt",  64'(stall_cnt),  64'd0);
        check("rst_selerr_cnt", 64'(selerr_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors, back-to-back with out_ready high
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].src, vecs[i].sel, '{vecs[i].ed, vecs[i].ee}, w);
            if (i == 0) check("latency_out_valid", 64'(out_valid), 64'd1);
        end
        idle();
        drain();
`ifdef FWD_SEL_STATS_EN
        check("selerr_cnt_table", 64'(selerr_cnt), 64'd3);
`else
        check("selerr_cnt_off", 64'(selerr_cnt), 64'd0);
`endif
        check("stall_cnt_none", 64'(stall_cnt), 64'd0);

        // Backpressure: two accepts fill the buffer, then release
        out_ready = 1'b0;
        f0 = nfire;
        send(vecs[0].src, vecs[0].sel, '{vecs[0].ed, vecs[0].ee}, w);
        send(vecs[4].src, vecs[4].sel, '{vecs[4].ed, vecs[4].ee}, w);
        check("full_in_ready",  64'(in_ready),  64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("stall_hold0",    out_data,       vecs[0].ed);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("stall_hold1",    out_data,       vecs[0].ed);
        check("full_in_ready2", 64'(in_ready),  64'd0);
        out_ready = 1'b1;
        drain();
        check("bp_fire_count", 64'(nfire - f0), 64'd2);

        // Streaming 100 random bundles
        waits_total = 0;
        f0 = nfire;
        for (int i = 0; i < 100; i++) begin
            r_src = {$urandom, $urandom, $urandom};
            r_sel = 4'($urandom_range(0, 15));
            send(r_src, r_sel, ref_sel(r_src, r_sel), w);
            waits_total += w;
        end
        idle();
        @(posedge clk);
        #1;
        check("stream_b2b_waits", 64'(waits_total), 64'd0);
        check("stream_count", 64'(nfire - f0), 64'd100);
        check("stream_sb_empty", 64'(sbq.size()), 64'd0);

        // Flush while FULL with a new bundle presented
        out_ready = 1'b0;
        r_src = 96'h00000003_00000002_00000001;
        send(r_src, 4'b0001, ref_sel(r_src, 4'b0001), w);
        send(r_src, 4'b1000, ref_sel(r_src, 4'b1000), w);
        src_data = 96'hFFFFFFFF_EEEEEEEE_DDDDDDDD;
        sel      = 4'b0110;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        sbq.delete();
        check("flush_full_out_valid", 64'(out_valid), 64'd0);
        check("flush_full_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_full_quiet", 64'(out_valid), 64'd0);

        // Flush in ONE with a same-cycle accept: the accept must be discarded
        out_ready = 1'b0;
        send(r_src, 4'b0010, ref_sel(r_src, 4'b0010), w);
        src_data = 96'h0000000C_0000000B_0000000A;
        sel      = 4'b0001;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        sbq.delete();
        check("flush_one_out_valid", 64'(out_valid), 64'd0);
        check("flush_one_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        e = ref_sel(vecs[5].src, vecs[5].sel);
        send(vecs[5].src, vecs[5].sel, e, w);
        idle();
        drain();

        // Asynchronous reset in the middle of a stalled transfer
        out_ready = 1'b0;
        send(vecs[2].src, vecs[2].sel, '{vecs[2].ed, vecs[2].ee}, w);
        idle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sbq.delete();
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data",  out_data,       64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

`ifdef FWD_SEL_STATS_EN
        // Long stall: the stall counter must stick at all-ones
        send(vecs[1].src, vecs[1].sel, '{vecs[1].ed, vecs[1].ee}, w);
        idle();
        repeat (70000) @(posedge clk);
        #1;
        check("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
        check("selerr_cnt_after_stall", 64'(selerr_cnt), 64'd1);
        out_ready = 1'b1;
        drain();
`endif

        out_ready = 1'b1;
        check("final_sb_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
